// File: rtl/memstream_pkg.sv
// Shared types and constants for the weight-RAM stream reader and its RAM wrapper.
package memstream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int RAM_RD_LATENCY = 2;

    // Width able to hold any credit value 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/memstream_fifo.sv
// Small synchronous FIFO with fall-through output; dout reads zero while empty.
module memstream_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = empty ? '0 : mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/memstream_rd.sv
// Streams RAM words START_ADDR..END_ADDR onto AXI-Stream using credit-based issue.
// Define MEMSTREAM_RD_LOOP_EN to wrap back to START_ADDR and stream indefinitely.
module memstream_rd
    import memstream_pkg::*;
#(
    parameter int DWIDTH     = 18,
    parameter int AWIDTH     = 10,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 2**AWIDTH - 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_rdq,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    localparam int                CW      = credit_width(FIFO_DEPTH);
    localparam logic [AWIDTH-1:0] START_A = AWIDTH'(START_ADDR);
    localparam logic [AWIDTH-1:0] END_A   = AWIDTH'(END_ADDR);
    localparam logic [CW:0]       DEPTH_C = (CW+1)'(FIFO_DEPTH);

    state_t                    state_reg, state_next;
    logic [AWIDTH-1:0]         addr_reg, addr_next;
    logic [CW-1:0]             outstanding_reg, outstanding_next;
    logic                      done_reg, done_next;
    logic [RAM_RD_LATENCY-1:0] vld_reg;
    logic [RAM_RD_LATENCY-1:0] last_reg;

    logic              issue;
    logic              issue_last;
    logic              credit_ok;
    logic              push;
    logic              pop;
    logic [DWIDTH:0]   fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign push       = vld_reg[RAM_RD_LATENCY-1];
    assign pop        = m_axis_tvalid && m_axis_tready;
    assign issue_last = (addr_reg == END_A);
    // Reserve a FIFO slot for every read in flight so RAM data is never dropped.
    assign credit_ok  = !fifo_full &&
                        (({1'b0, outstanding_reg} + {1'b0, fifo_count}) < DEPTH_C);

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        issue      = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    addr_next  = START_A;
                end
            end
            RUN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (issue_last) begin
`ifdef MEMSTREAM_RD_LOOP_EN
                        addr_next  = START_A;
`else
                        state_next = DRAIN;
`endif
                    end else begin
                        addr_next = addr_reg + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (pop && fifo_dout[DWIDTH] && (outstanding_reg == '0) &&
                    (fifo_count == CW'(1))) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
`ifdef MEMSTREAM_RD_LOOP_EN
        done_next = pop && fifo_dout[DWIDTH];
`endif
    end

    always_comb begin
        outstanding_next = outstanding_reg;
        case ({issue, push})
            2'b10:   outstanding_next = outstanding_reg + 1'b1;
            2'b01:   outstanding_next = outstanding_reg - 1'b1;
            default: outstanding_next = outstanding_reg;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg       <= IDLE;
            addr_reg        <= START_A;
            outstanding_reg <= '0;
            done_reg        <= 1'b0;
            vld_reg         <= '0;
            last_reg        <= '0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            outstanding_reg <= outstanding_next;
            done_reg        <= done_next;
            vld_reg         <= {vld_reg[RAM_RD_LATENCY-2:0], issue};
            last_reg        <= {last_reg[RAM_RD_LATENCY-2:0], issue && issue_last};
        end
    end

    memstream_fifo #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .push    (push),
        .din     ({last_reg[RAM_RD_LATENCY-1], mem_rdq}),
        .pop     (pop),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign busy          = (state_reg != IDLE);
    assign done          = done_reg;
    assign mem_addr      = addr_reg;
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_dout[DWIDTH-1:0];
    assign m_axis_tlast  = fifo_dout[DWIDTH];

endmodule

// File: tb/tb_memstream_rd.sv
// Scoreboard bench for memstream_rd: stimulus queues expected beats, monitors compare.
`timescale 1ns/1ps
module tb_memstream_rd;

    localparam int DW = 18;
    localparam int AW = 10;
`ifdef MEMSTREAM_RD_LOOP_EN
    localparam int MAIN_END = 3;
`else
    localparam int MAIN_END = 7;
`endif

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, tvalid, tlast;
    logic          tready = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdq, tdata;

    logic          e_start = 1'b0;
    logic          e_busy, e_done, e_tvalid, e_tlast;
    logic          e_tready = 1'b1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rdq, e_tdata;

    logic [DW-1:0] ram [1024];
    logic [AW-1:0] ra_reg, e_ra_reg;

    logic [DW:0] exp_q[$];
    logic [DW:0] e_q[$];
    int vectors = 0, miscompares = 0;
    int cyc = 0, beats = 0, prev_hs_cyc = 0, last_tl_cyc = -10, first_exp_cyc = 0;
    int dones = 0, e_dones = 0, e_last_cyc = -10, c0 = 0;
    bit chk_contig = 0, chk_first = 0, bp_en = 0, stalled = 0;
    logic [DW:0] held;

    memstream_rd #(.DWIDTH(DW), .AWIDTH(AW), .START_ADDR(0), .END_ADDR(MAIN_END), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .aresetn(aresetn), .start(start), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rdq(mem_rdq), .m_axis_tdata(tdata),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast));

    memstream_rd #(.DWIDTH(DW), .AWIDTH(AW), .START_ADDR(1023), .END_ADDR(1023), .FIFO_DEPTH(4)) u_edge (
        .clk(clk), .aresetn(aresetn), .start(e_start), .busy(e_busy), .done(e_done),
        .mem_addr(e_addr), .mem_rdq(e_rdq), .m_axis_tdata(e_tdata),
        .m_axis_tvalid(e_tvalid), .m_axis_tready(e_tready), .m_axis_tlast(e_tlast));

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = DW'(i + 'h100);
    end

    // Two-stage registered-read RAM models.
    always @(posedge clk) begin
        ra_reg   <= mem_addr;
        mem_rdq  <= ram[ra_reg];
        e_ra_reg <= e_addr;
        e_rdq    <= ram[e_ra_reg];
        cyc      <= cyc + 1;
    end

    always @(posedge clk) begin
        #1;
        if (bp_en) tready = ($urandom_range(0, 1) == 1);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (!aresetn) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                vectors++;
                if (!tvalid || {tlast, tdata} !== held) begin
                    miscompares++;
                    $display("FAIL stall_stable: got v=%0b %h want v=1 %h", tvalid, {tlast, tdata}, held);
                end
            end
            stalled = tvalid && !tready;
            held = {tlast, tdata};
            if (tvalid && tready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL beat_unexpected: got %h want none", {tlast, tdata});
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    if ({tlast, tdata} !== e) begin
                        miscompares++;
                        $display("FAIL beat%0d: got last=%0b data=%h want last=%0b data=%h",
                                 beats, tlast, tdata, e[DW], e[DW-1:0]);
                    end
                end
                if (chk_first && beats == 0 && cyc != first_exp_cyc) begin
                    miscompares++;
                    $display("FAIL first_latency: got cycle %0d want %0d", cyc, first_exp_cyc);
                end
                if (chk_contig && beats > 0 && cyc != prev_hs_cyc + 1) begin
                    miscompares++;
                    $display("FAIL gap: got cycle %0d want %0d", cyc, prev_hs_cyc + 1);
                end
                prev_hs_cyc = cyc;
                beats++;
                if (tlast) last_tl_cyc = cyc;
            end
            if (bp_en) begin
                vectors++;
                if (int'(u_dut.outstanding_reg) + int'(u_dut.fifo_count) > 4) begin
                    miscompares++;
                    $display("FAIL credit: got %0d want <=4",
                             int'(u_dut.outstanding_reg) + int'(u_dut.fifo_count));
                end
            end
            if (done) begin
                vectors++;
                dones++;
                if (cyc != last_tl_cyc + 1) begin
                    miscompares++;
                    $display("FAIL done_timing: got cycle %0d want %0d", cyc, last_tl_cyc + 1);
                end
`ifndef MEMSTREAM_RD_LOOP_EN
                if (busy) begin
                    miscompares++;
                    $display("FAIL busy_with_done: got busy=1 want 0");
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (aresetn) begin
            if (e_tvalid && e_tready) begin
                vectors++;
                if (e_q.size() == 0 || {e_tlast, e_tdata} !== e_q[0]) begin
                    miscompares++;
                    $display("FAIL edge_beat: got %h want %h", {e_tlast, e_tdata},
                             (e_q.size() != 0) ? e_q[0] : '0);
                end
                if (e_q.size() != 0) void'(e_q.pop_front());
                e_last_cyc = cyc;
            end
            if (e_done) begin
                vectors++;
                e_dones++;
                if (cyc != e_last_cyc + 1) begin
                    miscompares++;
                    $display("FAIL edge_done_timing: got cycle %0d want %0d", cyc, e_last_cyc + 1);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push_pass(input int hi);
        for (int i = 0; i <= hi; i++) exp_q.push_back({(i == hi), DW'(i + 'h100)});
    endtask

    task automatic start_main();
        beats = 0;
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        c0 = cyc;
        first_exp_cyc = c0 + 3;
        check("busy_after_start", busy, 1);
    endtask

    task automatic pulse_start();
        #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int budget, input string name);
        int n = 0;
        while (dones < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, (dones >= target), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, tvalid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_tlast"}, tlast, 0);
        check({tag, "_tdata"}, tdata, 0);
        check({tag, "_addr"}, mem_addr, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        check("rst_edge_addr", e_addr, 1023);
        check("rst_edge_tvalid", e_tvalid, 0);
        @(negedge clk); #1 aresetn = 1'b1;
        repeat (2) @(negedge clk);
`ifdef MEMSTREAM_RD_LOOP_EN
        chk_contig = 1; chk_first = 1;
        for (int p = 0; p < 4; p++) push_pass(MAIN_END);
        start_main();
        wait_dones(3, 100, "loop_three_dones");
        @(posedge clk); #1 tready = 1'b0;
        check("loop_busy", busy, 1);
        check("loop_beats", (beats >= 12), 1);
        @(negedge clk); #1 aresetn = 1'b0;
        exp_q.delete();
        #1 check_reset_outputs("loop_rst");
        @(negedge clk); #1 aresetn = 1'b1; tready = 1'b1;
        repeat (10) @(negedge clk);
        check("loop_quiet_after_rst", tvalid, 0);
`else
        // single pass, full throughput
        chk_contig = 1; chk_first = 1;
        push_pass(MAIN_END);
        start_main();
        wait_dones(1, 60, "pass1_done");
        repeat (3) @(negedge clk);
        check("pass1_idle", busy, 0);
        check("pass1_all_beats", exp_q.size(), 0);

        // random backpressure
        chk_contig = 0; chk_first = 0; bp_en = 1;
        push_pass(MAIN_END);
        start_main();
        wait_dones(2, 400, "bp_done");
        bp_en = 0;
        @(negedge clk); #1 tready = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_idle", busy, 0);
        check("bp_all_beats", exp_q.size(), 0);
        check("bp_beat_count", beats, 8);

        // start pulses while RUN and DRAIN are ignored
        chk_contig = 1; chk_first = 1;
        push_pass(MAIN_END);
        start_main();
        while (cyc < c0 + 3) @(negedge clk);
        check("busy_at_run_pulse", busy, 1);
        pulse_start();
        while (cyc < c0 + 9) @(negedge clk);
        check("busy_at_drain_pulse", busy, 1);
        pulse_start();
        wait_dones(3, 60, "ignore_done");
        repeat (20) @(negedge clk);
        check("ignore_idle", busy, 0);
        check("ignore_one_done", dones, 3);
        check("ignore_beat_count", beats, 8);

        // reset in the middle of a pass
        push_pass(MAIN_END);
        start_main();
        for (int n = 0; n < 100 && beats < 3; n++) @(posedge clk);
        @(negedge clk); #1 aresetn = 1'b0;
        exp_q.delete();
        #1 check_reset_outputs("midrst");
        @(negedge clk); #1 aresetn = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_quiet", tvalid, 0);
        check("midrst_idle", busy, 0);
        push_pass(MAIN_END);
        start_main();
        wait_dones(4, 60, "restart_done");
        repeat (3) @(negedge clk);
        check("restart_beats", beats, 8);
        check("restart_all_beats", exp_q.size(), 0);

        // single-address range at the top of the RAM
        e_q.push_back({1'b1, DW'('h4FF)});
        @(negedge clk); #1 e_start = 1'b1;
        @(negedge clk); #1 e_start = 1'b0;
        check("edge_busy", e_busy, 1);
        for (int n = 0; n < 40 && e_dones < 1; n++) @(posedge clk);
        @(negedge clk);
        check("edge_done", e_dones, 1);
        check("edge_all_beats", e_q.size(), 0);
        check("edge_idle", e_busy, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
